// File: rtl/sdr_cmd_monitor.sv
// rtl/sdr_cmd_monitor.sv - SDRAM command-bus monitor for init sequence, timing and refresh rules
//
// Watches the SDRAM command bus and raises sticky error flags when the
// controller breaks the power-up sequence, minimum command spacing or the
// refresh period.
//
// Optional build macro: SDR_MON_TIMING_CHECK_EN builds the tRP/tRFC/tMRD gap
// checks. Without it those checkers do not exist and ERR[4:2] stay 0.
//
// Ports:
//   CLK, RESET_N           clock and asynchronous active-low reset
//   SD_INIT                synchronous restart of the init tracker
//   CS_N, CKE              chip selects and clock enable
//   RAS_N, CAS_N, WE_N     command strobes
//   SA, BA, DQM            address, bank and data mask
//   RP, RFC, MRD           minimum clocks after PRE / REF / MRS
//   REF                    refresh period in clocks
//   ERR_CLR                clears sticky error flags
//   INIT_DONE, MODE_VALID  init complete, mode register captured
//   MODE_CL, MODE_BL       captured CAS latency / burst length fields
//   REF_COUNT              refreshes seen during init (saturates at 8)
//   ERR                    {DQM, REF_LATE, TMRD, TRFC, TRP, SEQ, ACCESS}
module sdr_cmd_monitor #(
  parameter int SDRAM_CHIPS = 8,
  parameter int REF_SLACK   = 16
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   SD_INIT,
  input  logic [SDRAM_CHIPS-1:0] CS_N,
  input  logic                   CKE,
  input  logic                   RAS_N,
  input  logic                   CAS_N,
  input  logic                   WE_N,
  input  logic [13:0]            SA,
  input  logic [1:0]             BA,
  input  logic                   DQM,
  input  logic [2:0]             RP,
  input  logic [3:0]             RFC,
  input  logic [2:0]             MRD,
  input  logic [15:0]            REF,
  input  logic                   ERR_CLR,
  output logic                   INIT_DONE,
  output logic                   MODE_VALID,
  output logic [2:0]             MODE_CL,
  output logic [2:0]             MODE_BL,
  output logic [3:0]             REF_COUNT,
  output logic [6:0]             ERR
);

  typedef enum logic [1:0] {S_W_PRE, S_W_REF, S_W_MRS, S_DONE} state_t;

  localparam logic [2:0] C_MRS = 3'b000;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_BST = 3'b110;
  localparam logic [2:0] C_NOP = 3'b111;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_init_done;
  logic        r_mode_valid;
  logic [2:0]  r_mode_cl;
  logic [2:0]  r_mode_bl;
  logic [3:0]  r_ref_count;
  logic [6:0]  r_err;
  logic [15:0] r_ref_clk;
  logic        r_late_seen;

  logic [2:0]  w_cmd;
  logic        w_active;
  logic        w_access;
  logic        w_seq_err;
  logic        w_capture;
  logic        w_ref_inc;
  logic        w_late;
  logic        w_trp;
  logic        w_trfc;
  logic        w_tmrd;
  logic [16:0] w_ref_limit;
  logic [6:0]  w_err_set;
  logic        w_unused;

  // A deselected or clock-disabled cycle is treated exactly like an explicit NOP.
  assign w_cmd    = (CKE && !(&CS_N)) ? {RAS_N, CAS_N, WE_N} : C_NOP;
  assign w_active = (w_cmd != C_NOP);
  assign w_access = (w_cmd == C_ACT) || (w_cmd == C_RD) || (w_cmd == C_WR);

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_W_PRE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (SD_INIT) begin
      w_state_nxt = S_W_PRE;
    end else begin
      case (r_state)
        S_W_PRE: if (w_cmd == C_PRE) w_state_nxt = S_W_REF;
        S_W_REF: if (w_cmd == C_REF && r_ref_count == 4'd7) w_state_nxt = S_W_MRS;
        S_W_MRS: if (w_cmd == C_MRS) w_state_nxt = S_DONE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Per-state decode of sequence errors, mode capture and refresh counting
  always_comb begin
    w_seq_err = 1'b0;
    w_capture = 1'b0;
    w_ref_inc = 1'b0;
    case (r_state)
      S_W_PRE: w_seq_err = w_active && (w_cmd != C_PRE);
      S_W_REF: begin
        w_seq_err = w_active && (w_cmd != C_PRE) && (w_cmd != C_REF);
        w_ref_inc = (w_cmd == C_REF);
      end
      S_W_MRS: begin
        w_seq_err = w_access || (w_cmd == C_BST);
        w_capture = (w_cmd == C_MRS);
      end
      default: w_capture = (w_cmd == C_MRS);
    endcase
  end

`ifdef SDR_MON_TIMING_CHECK_EN
  // Each counter holds the gap the current cycle would have to the last
  // PRE/REF/MRS; 15 means "long enough ago", so idle time never wraps.
  logic [3:0] r_gap_pre;
  logic [3:0] r_gap_ref;
  logic [3:0] r_gap_mrs;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_gap_pre <= 4'd15;
      r_gap_ref <= 4'd15;
      r_gap_mrs <= 4'd15;
    end else if (SD_INIT) begin
      // Restart forgets earlier commands rather than arming a fresh violation.
      r_gap_pre <= 4'd15;
      r_gap_ref <= 4'd15;
      r_gap_mrs <= 4'd15;
    end else begin
      r_gap_pre <= (w_cmd == C_PRE) ? 4'd1 : ((r_gap_pre == 4'd15) ? 4'd15 : r_gap_pre + 4'd1);
      r_gap_ref <= (w_cmd == C_REF) ? 4'd1 : ((r_gap_ref == 4'd15) ? 4'd15 : r_gap_ref + 4'd1);
      r_gap_mrs <= (w_cmd == C_MRS) ? 4'd1 : ((r_gap_mrs == 4'd15) ? 4'd15 : r_gap_mrs + 4'd1);
    end
  end

  assign w_trp    = w_active && (r_gap_pre < {1'b0, RP});
  assign w_trfc   = w_active && (r_gap_ref < RFC);
  assign w_tmrd   = w_active && (r_gap_mrs < {1'b0, MRD});
  assign w_unused = ^{SA[13:7], SA[3], BA};
`else
  assign w_trp    = 1'b0;
  assign w_trfc   = 1'b0;
  assign w_tmrd   = 1'b0;
  assign w_unused = ^{SA[13:7], SA[3], BA, RP, RFC, MRD};
`endif

  // r_ref_clk is zero in the cycle after a REF, so the gap is r_ref_clk+1 and
  // "gap > limit" reduces to r_ref_clk >= limit. 17 bits keep REF+slack exact.
  assign w_ref_limit = {1'b0, REF} + 17'(REF_SLACK);
  assign w_late      = (r_state == S_DONE) && !r_late_seen && ({1'b0, r_ref_clk} >= w_ref_limit);

  // DQM must stay high until the cycle after the init MRS, i.e. until DONE.
  assign w_err_set = {(!DQM && r_state != S_DONE), w_late, w_tmrd, w_trfc, w_trp,
                      w_seq_err, (w_access && r_state != S_DONE)};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_init_done  <= 1'b0;
      r_mode_valid <= 1'b0;
      r_mode_cl    <= 3'd0;
      r_mode_bl    <= 3'd0;
      r_ref_count  <= 4'd0;
      r_err        <= 7'd0;
      r_ref_clk    <= 16'd0;
      r_late_seen  <= 1'b0;
    end else begin
      r_init_done <= (w_state_nxt == S_DONE);
      // New errors win over a simultaneous clear.
      r_err <= (r_err & {7{~ERR_CLR}}) | w_err_set;
      if (w_capture) begin
        r_mode_cl <= SA[6:4];
        r_mode_bl <= SA[2:0];
      end
      if (SD_INIT) begin
        r_ref_count  <= 4'd0;
        r_mode_valid <= 1'b0;
      end else begin
        if (w_ref_inc && r_ref_count != 4'd8) r_ref_count <= r_ref_count + 4'd1;
        if (w_capture) r_mode_valid <= 1'b1;
      end
      if (SD_INIT || w_cmd == C_REF) begin
        r_ref_clk   <= 16'd0;
        r_late_seen <= 1'b0;
      end else begin
        if (r_ref_clk != 16'hFFFF) r_ref_clk <= r_ref_clk + 16'd1;
        if (w_late) r_late_seen <= 1'b1;
      end
    end
  end

  assign INIT_DONE  = r_init_done;
  assign MODE_VALID = r_mode_valid;
  assign MODE_CL    = r_mode_cl;
  assign MODE_BL    = r_mode_bl;
  assign REF_COUNT  = r_ref_count;
  assign ERR        = r_err;

endmodule

// File: tb/tb_sdr_cmd_monitor.sv
// tb/tb_sdr_cmd_monitor.sv - self-checking bench for sdr_cmd_monitor
module tb_sdr_cmd_monitor;

  localparam logic [2:0] C_MRS = 3'b000;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_BST = 3'b110;
  localparam logic [2:0] C_NOP = 3'b111;
  localparam int SLACK = 16;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b1;
  logic        SD_INIT = 1'b0;
  logic [7:0]  CS_N = 8'hFF;
  logic        CKE = 1'b0;
  logic        RAS_N = 1'b1;
  logic        CAS_N = 1'b1;
  logic        WE_N = 1'b1;
  logic [13:0] SA = 14'd0;
  logic [1:0]  BA = 2'd0;
  logic        DQM = 1'b1;
  logic [2:0]  RP = 3'd3;
  logic [3:0]  RFC = 4'd6;
  logic [2:0]  MRD = 3'd2;
  logic [15:0] REF = 16'hFFFF;
  logic        ERR_CLR = 1'b0;
  logic        INIT_DONE;
  logic        MODE_VALID;
  logic [2:0]  MODE_CL;
  logic [2:0]  MODE_BL;
  logic [3:0]  REF_COUNT;
  logic [6:0]  ERR;

  int   n_total = 0;
  int   n_bad = 0;
  logic dqm_lvl = 1'b1;

  // Reference model: init phase 0..3 (W_PRE, W_REF, W_MRS, DONE), cycle
  // stamps of the last PRE/REF/MRS and last refresh.
  int          cyc = 0;
  int          m_phase;
  int          m_refs;
  logic        m_valid;
  logic [2:0]  m_cl;
  logic [2:0]  m_bl;
  logic [6:0]  m_err;
  int          m_last_pre;
  int          m_last_ref;
  int          m_last_mrs;
  int          m_last_refresh;
  logic        m_late_flag;
  logic [6:0]  exp_err;

  sdr_cmd_monitor #(.SDRAM_CHIPS(8), .REF_SLACK(SLACK)) u_dut (
    .CLK(CLK), .RESET_N(RESET_N), .SD_INIT(SD_INIT), .CS_N(CS_N), .CKE(CKE),
    .RAS_N(RAS_N), .CAS_N(CAS_N), .WE_N(WE_N), .SA(SA), .BA(BA), .DQM(DQM),
    .RP(RP), .RFC(RFC), .MRD(MRD), .REF(REF), .ERR_CLR(ERR_CLR),
    .INIT_DONE(INIT_DONE), .MODE_VALID(MODE_VALID), .MODE_CL(MODE_CL),
    .MODE_BL(MODE_BL), .REF_COUNT(REF_COUNT), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int gap_of(input int last);
    int g;
    g = cyc - last;
    return (g > 15) ? 15 : g;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_refs = 0; m_valid = 1'b0; m_cl = 3'd0; m_bl = 3'd0; m_err = 7'd0;
    m_last_pre = -1000; m_last_ref = -1000; m_last_mrs = -1000;
    m_last_refresh = cyc; m_late_flag = 1'b0;
  endtask

  task automatic model_step();
    int c;
    int nphase;
    logic [6:0] e;
    cyc++;
    c = (CKE && CS_N != 8'hFF) ? int'({RAS_N, CAS_N, WE_N}) : int'(C_NOP);
    e = 7'd0;
    nphase = m_phase;
    if (!DQM && m_phase != 3) e[6] = 1'b1;
    if ((c == C_ACT || c == C_RD || c == C_WR) && m_phase != 3) e[0] = 1'b1;
    case (m_phase)
      0: if (c != C_NOP) begin
           if (c == C_PRE) nphase = 1; else e[1] = 1'b1;
         end
      1: if (c == C_REF) begin
           if (m_refs < 8) m_refs++;
           if (m_refs == 8) nphase = 2;
         end else if (c != C_NOP && c != C_PRE) e[1] = 1'b1;
      2: if (c == C_MRS) begin
           nphase = 3; m_cl = SA[6:4]; m_bl = SA[2:0]; m_valid = 1'b1;
         end else if (c == C_ACT || c == C_RD || c == C_WR || c == C_BST) e[1] = 1'b1;
      default: if (c == C_MRS) begin
           m_cl = SA[6:4]; m_bl = SA[2:0]; m_valid = 1'b1;
         end
    endcase
`ifdef SDR_MON_TIMING_CHECK_EN
    if (c != C_NOP) begin
      if (gap_of(m_last_pre) < int'(RP))  e[2] = 1'b1;
      if (gap_of(m_last_ref) < int'(RFC)) e[3] = 1'b1;
      if (gap_of(m_last_mrs) < int'(MRD)) e[4] = 1'b1;
    end
`endif
    if (c == C_PRE) m_last_pre = cyc;
    if (c == C_REF) m_last_ref = cyc;
    if (c == C_MRS) m_last_mrs = cyc;
    if (m_phase == 3 && !m_late_flag && (cyc - m_last_refresh) > int'(REF) + SLACK) begin
      e[5] = 1'b1; m_late_flag = 1'b1;
    end
    if (c == C_REF) begin
      m_last_refresh = cyc; m_late_flag = 1'b0;
    end
    if (SD_INIT) begin
      nphase = 0; m_refs = 0; m_valid = 1'b0;
      m_last_pre = -1000; m_last_ref = -1000; m_last_mrs = -1000;
      m_last_refresh = cyc; m_late_flag = 1'b0;
    end
    m_err = (ERR_CLR ? 7'd0 : m_err) | e;
    m_phase = nphase;
  endtask

  task automatic check_all();
    chk("init_done", 32'(INIT_DONE), 32'(m_phase == 3));
    chk("mode_valid", 32'(MODE_VALID), 32'(m_valid));
    chk("mode_cl", 32'(MODE_CL), 32'(m_cl));
    chk("mode_bl", 32'(MODE_BL), 32'(m_bl));
    chk("ref_count", 32'(REF_COUNT), 32'(m_refs));
    chk("err", 32'(ERR), 32'(m_err));
  endtask

  task automatic step();
    @(posedge CLK);
    model_step();
    #1;
    check_all();
  endtask

  task automatic drive(input logic [2:0] c);
    int idx;
    DQM = dqm_lvl;
    SA  = 14'($urandom);
    BA  = 2'($urandom);
    idx = $urandom_range(0, 7);
    if (c == C_NOP) begin
      case ($urandom_range(0, 2))
        0: begin CKE = 1'b1; CS_N = 8'hFF; {RAS_N, CAS_N, WE_N} = 3'($urandom); end
        1: begin CKE = 1'b0; CS_N = 8'hFF; CS_N[idx] = 1'b0; {RAS_N, CAS_N, WE_N} = 3'($urandom); end
        default: begin CKE = 1'b1; CS_N = 8'hFF; CS_N[idx] = 1'b0; {RAS_N, CAS_N, WE_N} = C_NOP; end
      endcase
    end else begin
      CKE = 1'b1; CS_N = 8'hFF; CS_N[idx] = 1'b0; {RAS_N, CAS_N, WE_N} = c;
    end
  endtask

  task automatic do_cmd(input logic [2:0] c);
    drive(c);
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cmd(C_NOP);
  endtask

  task automatic do_mrs(input logic [13:0] sa);
    drive(C_MRS);
    SA = sa;
    step();
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    #1;
    model_reset();
    chk("rst_init_done", 32'(INIT_DONE), 32'd0);
    chk("rst_mode_valid", 32'(MODE_VALID), 32'd0);
    chk("rst_mode_cl", 32'(MODE_CL), 32'd0);
    chk("rst_mode_bl", 32'(MODE_BL), 32'd0);
    chk("rst_ref_count", 32'(REF_COUNT), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    RESET_N = 1'b1;
  endtask

  task automatic pulse_sd_init();
    SD_INIT = 1'b1;
    idle(1);
    SD_INIT = 1'b0;
  endtask

  task automatic clear_err();
    ERR_CLR = 1'b1;
    idle(1);
    ERR_CLR = 1'b0;
  endtask

  initial begin
    int r;
    logic [2:0] cmd;
    #2;
    do_reset();

    // Clean init: PRE, 8 REF ten clocks apart, MRS with CL=3 BL=2, DQM low after.
    do_cmd(C_PRE); idle(9);
    repeat (8) begin do_cmd(C_REF); idle(9); end
    do_mrs(14'h032);
    dqm_lvl = 1'b0;
    idle(1);
    chk("init_done_set", 32'(INIT_DONE), 32'd1);
    chk("mode_valid_set", 32'(MODE_VALID), 32'd1);
    chk("mode_cl_3", 32'(MODE_CL), 32'd3);
    chk("mode_bl_2", 32'(MODE_BL), 32'd2);
    chk("ref_count_8", 32'(REF_COUNT), 32'd8);
    chk("init_err_clean", 32'(ERR), 32'd0);

    // Refresh lateness with REF=100: REF at gap 116 is fine, gap 117 is late.
    REF = 16'd100;
    idle(2);
    do_cmd(C_REF); idle(115); do_cmd(C_REF);
    chk("ref_at_116_ok", 32'(ERR), 32'd0);
    idle(116);
    chk("ref_gap_116_ok", 32'(ERR[5]), 32'd0);
    idle(1);
    chk("ref_gap_117_late", 32'(ERR), 32'h20);
    clear_err();
    idle(20);
    chk("ref_late_once", 32'(ERR), 32'd0);

    // Short init: PRE, 5 REF, MRS.
    dqm_lvl = 1'b1;
    pulse_sd_init();
    chk("sd_init_done_clr", 32'(INIT_DONE), 32'd0);
    chk("sd_init_valid_clr", 32'(MODE_VALID), 32'd0);
    do_cmd(C_PRE); idle(9);
    repeat (5) begin do_cmd(C_REF); idle(9); end
    do_mrs(14'h0);
    chk("early_mrs_seq", 32'(ERR), 32'h02);
    chk("early_mrs_count", 32'(REF_COUNT), 32'd5);
    chk("early_mrs_not_done", 32'(INIT_DONE), 32'd0);
    clear_err();
    chk("err_clr", 32'(ERR), 32'd0);

    // tRP: REF two clocks after PRE with RP=3, then exactly at RP.
    pulse_sd_init();
    do_cmd(C_PRE); idle(1); do_cmd(C_REF);
`ifdef SDR_MON_TIMING_CHECK_EN
    exp_err = 7'h04;
`else
    exp_err = 7'h00;
`endif
    chk("trp_short", 32'(ERR), 32'(exp_err));
    clear_err();
    idle(10);
    do_cmd(C_PRE); idle(2); do_cmd(C_REF);
    chk("trp_exact_ok", 32'(ERR), 32'd0);
    chk("trp_ref_count", 32'(REF_COUNT), 32'd2);

    // Access before init, clear colliding with a new error, reset mid-train.
    pulse_sd_init();
    do_cmd(C_PRE); idle(9);
    do_cmd(C_ACT);
    chk("act_early", 32'(ERR), 32'h03);
    ERR_CLR = 1'b1;
    do_cmd(C_RD);
    ERR_CLR = 1'b0;
    chk("clr_vs_new_err", 32'(ERR), 32'h03);
    clear_err();
    chk("err_clr2", 32'(ERR), 32'd0);
    do_cmd(C_PRE); idle(9);
    do_cmd(C_REF); idle(9);
    do_cmd(C_REF); idle(3);
    do_reset();
    idle(2);
    do_cmd(C_REF);
    chk("restart_ref_seq", 32'(ERR), 32'h02);
    chk("restart_ref_count", 32'(REF_COUNT), 32'd0);

    // Randomized traffic against the model.
    clear_err();
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) begin
        RP  = 3'($urandom);
        RFC = 4'($urandom);
        MRD = 3'($urandom);
        REF = 16'($urandom_range(4, 40));
      end
      if (i == 750) do_reset();
      SD_INIT = ($urandom_range(0, 299) == 0);
      ERR_CLR = ($urandom_range(0, 19) == 0);
      dqm_lvl = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 11);
      cmd = (r > 7) ? C_NOP : 3'(r);
      do_cmd(cmd);
    end
    SD_INIT = 1'b0;
    ERR_CLR = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/sdr_cmd_monitor.md
SDR_CMD_MONITOR -- requirements
Module: sdr_cmd_monitor

Interface
REQ-001 SHALL have parameter SDRAM_CHIPS, default 8, meaning width of CS_N.
REQ-002 SHALL have parameter REF_SLACK, default 16, meaning clocks of refresh lateness tolerated beyond REF.
REQ-003 SHALL have ports:
- CLK  input  1  sole clock; all state on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- SD_INIT  input  1  synchronous restart of the init tracker.
- CS_N  input  SDRAM_CHIPS  chip selects.
- CKE  input  1  SDRAM clock enable.
- RAS_N, CAS_N, WE_N  input  1 each  command strobes.
- SA  input  14  address bus.
- BA  input  2  bank select.
- DQM  input  1  data mask.
- RP  input  3  min PRE to next command, clocks.
- RFC  input  4  min REF to next command, clocks.
- MRD  input  3  min MRS to next command, clocks.
- REF  input  16  refresh period, clocks.
- ERR_CLR  input  1  clears sticky error flags.
- INIT_DONE  output  1  init sequence observed complete.
- MODE_VALID  output  1  mode register captured.
- MODE_CL  output  3  captured SA[6:4].
- MODE_BL  output  3  captured SA[2:0].
- REF_COUNT  output  4  refreshes seen during init, saturating at 8.
- ERR  output  7  sticky flags {DQM, REF_LATE, TMRD, TRFC, TRP, SEQ, ACCESS} (bit6..bit0).

Function
REQ-004 SHALL decode a command only when CKE=1 and any CS_N bit is 0; otherwise the cycle is NOP.
REQ-005 SHALL decode {RAS_N,CAS_N,WE_N}: 011 ACT, 101 RD, 100 WR, 010 PRE, 001 REF, 000 MRS, 110 BST, 111 NOP.
REQ-006 SHALL track init with states W_PRE -> W_REF -> W_MRS -> DONE.
REQ-007 W_PRE: PRE -> W_REF; any other non-NOP command sets ERR[1] (SEQ), state held.
REQ-008 W_REF: each REF increments REF_COUNT; REF_COUNT reaching 8 -> W_MRS; PRE allowed, no transition; MRS, ACT, RD, WR, BST set ERR[1], state held.
REQ-009 W_MRS: MRS -> DONE, capture MODE_CL/MODE_BL, set MODE_VALID; further REF and PRE allowed; ACT, RD, WR, BST set ERR[1].
REQ-010 DONE: INIT_DONE=1; MRS recaptures mode fields; every command legal for sequence purposes.
REQ-011 ACT, RD or WR decoded while not in DONE SHALL also set ERR[0] (ACCESS).
REQ-012 Gap between commands at cycles n and m is m-n; a non-NOP command with gap < RP after PRE sets ERR[2]; gap < RFC after REF sets ERR[3]; gap < MRD after MRS sets ERR[4].
REQ-013 Gap counters SHALL saturate at 15 so idle time never wraps into a false violation.
REQ-014 In DONE, a 16-bit saturating counter SHALL count clocks since the last REF; exceeding REF+REF_SLACK sets ERR[5] once per interval; next REF zeroes the counter.
REQ-015 REF+REF_SLACK SHALL be computed in 17 bits, no overflow.
REQ-016 DQM=0 in any cycle from reset up to and including the MRS cycle SHALL set ERR[6]; DQM=0 from the cycle after MRS onward is legal.
REQ-017 ERR bits SHALL be sticky until ERR_CLR=1; ERR_CLR and a new error in the same cycle leaves that bit set.
REQ-018 Outputs SHALL be registered; flags assert one clock after the offending command.
REQ-019 SD_INIT=1 SHALL return the tracker to W_PRE and clear REF_COUNT, MODE_VALID, INIT_DONE and all gap and refresh counters; ERR is unaffected.

Reset
REQ-020 RESET_N=0 SHALL asynchronously force state W_PRE, INIT_DONE=0, MODE_VALID=0, MODE_CL=0, MODE_BL=0, REF_COUNT=0, ERR=0, and all gap counters to 15.
REQ-021 Reset asserted mid-sequence SHALL discard all progress; tracking restarts at W_PRE after release.

Configuration
REQ-022 With macro SDR_MON_TIMING_CHECK_EN defined, the tRP/tRFC/tMRD checks of REQ-012/013 SHALL be built.
REQ-023 Without SDR_MON_TIMING_CHECK_EN, gap counters SHALL be absent and ERR[4:2] tied 0; all other behaviour is unchanged.

Verification
REQ-024 PRE, 8 REF each 10 clocks apart, MRS with SA=0x032, DQM low 1 clock later -> INIT_DONE=1, MODE_CL=3, MODE_BL=2, ERR=0.
REQ-025 RP=3, PRE then REF 2 clocks later -> ERR[2]=1 (macro on); ERR[2]=0 (macro off).
REQ-026 PRE, 5 REF, MRS -> ERR[1]=1, REF_COUNT=5, INIT_DONE=0; ERR_CLR -> ERR=0.
REQ-027 After init, REF=100, no REF for 117 clocks -> ERR[5]=1 at clock 117 only; REF at 116 -> ERR[5]=0.
REQ-028 ACT before MRS -> ERR[0]=1 and ERR[1]=1; RESET_N low mid-refresh-train -> all outputs 0, restart required.
